// File: rtl/intersection_phase_scheduler.sv
// Tick-timed phase scheduler for a two-way intersection with a pedestrian all-walk phase.
// Round-robin service of NS, EW and pedestrian requests with min/max green, yellow, all-red and walk timing.
module intersection_phase_scheduler #(
   parameter int CLK_PER_TICK = 1,
   parameter int MIN_GREEN    = 5,
   parameter int MAX_GREEN    = 15,
   parameter int YELLOW       = 3,
   parameter int ALL_RED      = 1,
   parameter int WALK         = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       NS_sensor,
   input  logic       EW_sensor,
   input  logic       ped_req,
   output logic [2:0] NS_light,
   output logic [2:0] EW_light,
   output logic       walk,
   output logic [2:0] phase
);

   localparam int DMAX_A = (MIN_GREEN > MAX_GREEN) ? MIN_GREEN : MAX_GREEN;
   localparam int DMAX_B = (YELLOW > ALL_RED) ? YELLOW : ALL_RED;
   localparam int DMAX_C = (DMAX_A > DMAX_B) ? DMAX_A : DMAX_B;
   localparam int DMAX   = (DMAX_C > WALK) ? DMAX_C : WALK;
   localparam int TW     = $clog2(DMAX) + 1;
   localparam int PW     = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;

   localparam logic [TW:0]   MIN_C    = (TW+1)'(MIN_GREEN);
   localparam logic [TW:0]   MAX_C    = (TW+1)'(MAX_GREEN);
   localparam logic [TW:0]   YEL_C    = (TW+1)'(YELLOW);
   localparam logic [TW:0]   AR_C     = (TW+1)'(ALL_RED);
   localparam logic [TW:0]   WALK_C   = (TW+1)'(WALK);
   localparam logic [TW-1:0] TSAT_C   = TW'(MAX_GREEN);
   localparam logic [PW-1:0] PRE_TC_C = PW'(CLK_PER_TICK - 1);

   localparam logic [1:0] SRV_NS  = 2'd0;
   localparam logic [1:0] SRV_EW  = 2'd1;
   localparam logic [1:0] SRV_PED = 2'd2;

   localparam logic [2:0] LAMP_R = 3'b100;
   localparam logic [2:0] LAMP_Y = 3'b010;
   localparam logic [2:0] LAMP_G = 3'b001;

   typedef enum logic [2:0] {
      S_ALLRED = 3'd0,
      S_NS_G   = 3'd1,
      S_NS_Y   = 3'd2,
      S_EW_G   = 3'd3,
      S_EW_Y   = 3'd4,
      S_WALK   = 3'd5
   } state_t;

   state_t        state_reg, state_next, rr_next;
   logic [TW-1:0] timer_reg;
   logic [PW-1:0] presc_reg;
   logic          ns_p_reg, ew_p_reg, ped_p_reg;
   logic [1:0]    last_reg;
   logic          tick;
   logic          entering;
   logic [TW:0]   elapsed;
   logic [2:0]    ns_lamp_next, ew_lamp_next;
   logic          walk_next;

   assign tick     = (presc_reg == PRE_TC_C);
   // Elapsed ticks in this state, counting the tick happening at this edge.
   assign elapsed  = {1'b0, timer_reg} + (TW+1)'(tick);
   assign entering = (state_next != state_reg);

   // First pending phase after the one served last; NS is the resting fallback.
   always_comb begin
      rr_next = S_NS_G;
      case (last_reg)
         SRV_NS: begin
            if (ew_p_reg)       rr_next = S_EW_G;
            else if (ped_p_reg) rr_next = S_WALK;
            else                rr_next = S_NS_G;
         end
         SRV_EW: begin
            if (ped_p_reg)      rr_next = S_WALK;
            else if (ns_p_reg)  rr_next = S_NS_G;
            else if (ew_p_reg)  rr_next = S_EW_G;
            else                rr_next = S_NS_G;
         end
         default: begin
            if (ns_p_reg)       rr_next = S_NS_G;
            else if (ew_p_reg)  rr_next = S_EW_G;
            else if (ped_p_reg) rr_next = S_WALK;
            else                rr_next = S_NS_G;
         end
      endcase
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_ALLRED: if (tick && elapsed >= AR_C) state_next = rr_next;
         S_NS_G: begin
            if (tick && (ew_p_reg || ped_p_reg) && elapsed >= MIN_C &&
                (!NS_sensor || elapsed >= MAX_C))
               state_next = S_NS_Y;
         end
         S_NS_Y:   if (tick && elapsed >= YEL_C) state_next = S_ALLRED;
         S_EW_G: begin
            if (tick && (ns_p_reg || ped_p_reg) && elapsed >= MIN_C &&
                (!EW_sensor || elapsed >= MAX_C))
               state_next = S_EW_Y;
         end
         S_EW_Y:   if (tick && elapsed >= YEL_C) state_next = S_ALLRED;
         S_WALK:   if (tick && elapsed >= WALK_C) state_next = S_ALLRED;
         default:  state_next = S_ALLRED;
      endcase
   end

   always_comb begin
      ns_lamp_next = LAMP_R;
      ew_lamp_next = LAMP_R;
      walk_next    = 1'b0;
      case (state_next)
         S_NS_G:  ns_lamp_next = LAMP_G;
         S_NS_Y:  ns_lamp_next = LAMP_Y;
         S_EW_G:  ew_lamp_next = LAMP_G;
         S_EW_Y:  ew_lamp_next = LAMP_Y;
         S_WALK:  walk_next    = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= S_ALLRED;
         timer_reg <= '0;
         presc_reg <= '0;
         ns_p_reg  <= 1'b0;
         ew_p_reg  <= 1'b0;
         ped_p_reg <= 1'b0;
         last_reg  <= SRV_PED;
         NS_light  <= LAMP_R;
         EW_light  <= LAMP_R;
         walk      <= 1'b0;
         phase     <= 3'd0;
      end else begin
         presc_reg <= tick ? '0 : presc_reg + 1'b1;
         state_reg <= state_next;

         if (entering)
            timer_reg <= '0;
         else if (tick && timer_reg < TSAT_C)
            timer_reg <= timer_reg + 1'b1;

         // Clear on entry to the serving state beats a same-cycle set.
         if (entering && state_next == S_NS_G)
            ns_p_reg <= 1'b0;
         else if (NS_sensor && state_reg != S_NS_G)
            ns_p_reg <= 1'b1;

         if (entering && state_next == S_EW_G)
            ew_p_reg <= 1'b0;
         else if (EW_sensor && state_reg != S_EW_G)
            ew_p_reg <= 1'b1;

         if (entering && state_next == S_WALK)
            ped_p_reg <= 1'b0;
         else if (ped_req && state_reg != S_WALK)
            ped_p_reg <= 1'b1;

         if (entering) begin
            case (state_next)
               S_NS_G:  last_reg <= SRV_NS;
               S_EW_G:  last_reg <= SRV_EW;
               S_WALK:  last_reg <= SRV_PED;
               default: ;
            endcase
         end

         NS_light <= ns_lamp_next;
         EW_light <= ew_lamp_next;
         walk     <= walk_next;
         phase    <= state_next;
      end
   end

endmodule

// File: doc/intersection_phase_scheduler.md
# intersection_phase_scheduler

Tick-timed phase scheduler for a two-way intersection with a pedestrian all-walk phase. It arbitrates round-robin between NS vehicle, EW vehicle and pedestrian requests, and enforces minimum green, maximum green, yellow, all-red clearance and walk durations. It drives the NS/EW lamp buses and the walk lamp directly, and sits in the same slot as the traffic light controller at board top level.

## Interface
- CLK_PER_TICK, 1: clocks per timing tick. The board build sets 100_000_000 for 1 s ticks.
- MIN_GREEN, 5: minimum green length, in ticks.
- MAX_GREEN, 15: maximum green length under contention, in ticks.
- YELLOW, 3: yellow length, in ticks.
- ALL_RED, 1: all-red clearance length, in ticks.
- WALK, 8: pedestrian walk length, in ticks.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- NS_sensor  in  1  level: vehicle present on NS.
- EW_sensor  in  1  level: vehicle present on EW.
- ped_req  in  1  pedestrian button. Any high cycle registers a request.
- NS_light  out  3  {R,Y,G} one-hot: 100 red, 010 yellow, 001 green.
- EW_light  out  3  same encoding as NS_light.
- walk  out  1  walk lamp.
- phase  out  3  current state code.

## Operation
- States and phase codes: ALLRED=0, NS_G=1, NS_Y=2, EW_G=3, EW_Y=4, WALK=5.
- Lamp outputs per state:
  - NS_G: NS 001, EW 100.
  - NS_Y: NS 010, EW 100.
  - EW_G: EW 001, NS 100.
  - EW_Y: EW 010, NS 100.
  - ALLRED: both lamps 100.
  - WALK: both lamps 100, walk=1.
  - walk=0 in every other state.
- Outputs are Moore, decoded from the state register.
- Pending flags ns_p, ew_p and ped_p are set when their input is high, and are held until served.
  - ns_p is cleared on entry to NS_G. It is not set while in NS_G.
  - ew_p follows the same rule for EW_G.
  - ped_p is cleared on entry to WALK. ped_req is ignored while in WALK.
  - If set and clear occur in the same cycle, clear wins.
- Green exit rule: the green state goes to its yellow on a tick when all of the following hold. The elapsed count includes the current tick.
  - A conflicting pending flag is set. For NS_G the conflicts are ew_p|ped_p; for EW_G they are ns_p|ped_p.
  - elapsed ≥ MIN_GREEN.
  - Either the own sensor is 0, or elapsed ≥ MAX_GREEN.
- With no conflict pending, green rests indefinitely. There is no forced change.
- Fixed transitions:
  - Y state → ALLRED after YELLOW ticks.
  - WALK → ALLRED after WALK ticks.
- Leaving ALLRED after ALL_RED ticks: pick the first pending phase in round-robin order, starting after last_served.
  - Order is NS(0) → EW(1) → PED(2) → NS.
  - If nothing is pending, enter NS_G (NS is the rest phase).
  - last_served is updated when the green or WALK state is entered.
- Tick generator: prescaler counts 0..CLK_PER_TICK-1. tick is high in the cycle the prescaler is at its terminal count. With CLK_PER_TICK=1, tick is high every cycle.
- State timer:
  - Cleared on every state entry.
  - Increments on tick and saturates at MAX_GREEN.
  - Width is clog2 of the largest duration parameter plus 1.
- Reset:
  - state=ALLRED, NS_light=100, EW_light=100, walk=0, phase=0.
  - All pending flags are 0; timer and prescaler are 0; last_served=PED, so NS is served first.
  - rst asserted mid-phase, including mid-yellow, forces ALLRED on the next edge and discards all pending flags.

## Timing
- A state of duration D, entered at edge k with CLK_PER_TICK=1, occupies cycles k..k+D-1. The next state is visible after edge k+D.
- The green exit decision is made on the tick edge itself, so yellow is visible in the cycle after the qualifying tick.
- A sensor pulse of one cycle is sufficient. It is latched at the next edge, and the green exit rule sees it on the following tick.
- The prescaler free-runs and is not realigned on state change. A state may therefore last up to one tick minus one clock less than nominal when CLK_PER_TICK>1.

## Test plan
- Reset, defaults:
  - During and after rst=1 for 2 cycles: NS_light=100, EW_light=100, walk=0, phase=0.
  - After release: 1 cycle ALLRED, then NS_G (NS_light=001).
  - With all inputs 0, phase stays at 1 for 50 cycles.
- Both sensors held 1: sequence is NS_G 15, NS_Y 3, ALLRED 1, EW_G 15, EW_Y 3, ALLRED 1, giving a repeating period of 38 cycles.
- NS resting in green for 20 cycles, NS_sensor=0, one-cycle EW_sensor pulse: NS_Y appears 2 cycles after the pulse, followed by 3 cycles NS_Y, 1 cycle ALLRED, then EW_G resting.
- EW_sensor=1 at cycle 2 of NS_G with NS_sensor=0: NS_G holds until elapsed=5, then NS_Y.
- During EW_G with NS_sensor=1 and EW_sensor=0, pulse ped_req: expect EW_Y, ALLRED, then WALK for 8 cycles (walk=1, both lamps 100), then ALLRED, then NS_G (PED is served before NS).
- rst pulsed during NS_Y with ew_p set: next cycle is ALLRED, then NS_G resting. ew_p was discarded, so no EW service occurs unless a new request arrives.
